// File: rtl/i2c_mem_access_ctrl.sv
// I2C subordinate memory-access controller: multi-byte address phase, RAM write/read
// sequencing with configurable read latency, wrap/stop pointer, and write protection.
module i2c_mem_access_ctrl #(
    parameter int ADDR_BYTES = 2,
    parameter int MEM_AW     = 10,
    parameter int RD_LATENCY = 1,
    parameter bit WRAP_EN    = 1'b1,
    parameter bit WP_EN      = 1'b0,
    parameter int WP_BASE    = 2**MEM_AW - 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_det,
    input  logic              stop_det,
    input  logic              hdr_valid,
    input  logic              hdr_rw,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              resp_valid,
    output logic              resp_nack,
    input  logic              tx_req,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    input  logic              mack_valid,
    input  logic              mack_nack,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err
);
    localparam int SHW = ADDR_BYTES * 8;
    localparam logic [1:0]        LAST_BYTE = 2'(ADDR_BYTES - 1);
    localparam logic [2:0]        LAT_END   = 3'(RD_LATENCY);
    localparam logic [MEM_AW-1:0] PTR_MAX   = {MEM_AW{1'b1}};
    localparam logic [MEM_AW:0]   WP_LIM    = (MEM_AW + 1)'(WP_BASE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_WR_DATA   = 3'd2,
        S_RD_IDLE   = 3'd3,
        S_RD_FETCH  = 3'd4,
        S_RD_WAIT   = 3'd5,
        S_IGNORE    = 3'd6
    } state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [SHW-1:0]    shift_q;
    logic [MEM_AW-1:0] ptr_q;
    logic              ovf_q;
    logic              pend_q;
    logic              ff_q;
    logic [2:0]        lat_q;
    logic              resp_valid_q, resp_nack_q, tx_valid_q, mem_we_q, mem_re_q, err_q;
    logic [7:0]        tx_byte_q, mem_wdata_q;
    logic [MEM_AW-1:0] mem_addr_q;

    logic [SHW-1:0]    addr_new_s;
    logic              addr_ok_s;
    logic              at_top_s;
    logic              ovf_inc_s;
    logic [MEM_AW-1:0] ptr_inc_s;
    logic              writable_s;

    assign addr_new_s = SHW'({shift_q, rx_byte});
    assign addr_ok_s  = ((addr_new_s >> MEM_AW) == {SHW{1'b0}});
    assign at_top_s   = (ptr_q == PTR_MAX);
    assign ovf_inc_s  = at_top_s && !WRAP_EN;
    assign ptr_inc_s  = ovf_inc_s ? ptr_q : ptr_q + MEM_AW'(1);
    assign writable_s = !WP_EN || ({1'b0, ptr_q} < WP_LIM);

    // Transaction FSM, pointer/overflow tracking and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            shift_q      <= {SHW{1'b0}};
            ptr_q        <= {MEM_AW{1'b0}};
            ovf_q        <= 1'b0;
            pend_q       <= 1'b0;
            ff_q         <= 1'b0;
            lat_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_nack_q  <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_wdata_q  <= 8'h00;
            mem_addr_q   <= {MEM_AW{1'b0}};
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            err_q        <= 1'b0;
            if (pend_q) begin
                lat_q <= lat_q + 3'd1;
            end
            if (stop_det || start_det) begin
                // Bus framing overrides everything, including a read still in flight
                state_q <= S_IDLE;
                pend_q  <= 1'b0;
            end else begin
                if (pend_q && (lat_q == LAT_END)) begin
                    pend_q     <= 1'b0;
                    tx_valid_q <= 1'b1;
                    tx_byte_q  <= ff_q ? 8'hFF : mem_rdata;
                    if (state_q == S_RD_FETCH) begin
                        state_q <= S_RD_WAIT;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (hdr_valid) begin
                            state_q <= hdr_rw ? S_RD_IDLE : S_ADDR;
                            cnt_q   <= 2'd0;
                        end
                    end
                    S_ADDR: begin
                        if (tx_req) begin
                            err_q <= 1'b1;
                        end
                        if (rx_valid) begin
                            resp_valid_q <= 1'b1;
                            shift_q      <= addr_new_s;
                            if (cnt_q == LAST_BYTE) begin
                                if (addr_ok_s) begin
                                    ptr_q       <= addr_new_s[MEM_AW-1:0];
                                    ovf_q       <= 1'b0;
                                    resp_nack_q <= 1'b0;
                                    state_q     <= S_WR_DATA;
                                end else begin
                                    resp_nack_q <= 1'b1;
                                    state_q     <= S_IGNORE;
                                end
                            end else begin
                                cnt_q       <= cnt_q + 2'd1;
                                resp_nack_q <= 1'b0;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (tx_req) begin
                            err_q <= 1'b1;
                        end
                        if (hdr_valid) begin
                            state_q <= hdr_rw ? S_RD_IDLE : S_ADDR;
                            cnt_q   <= 2'd0;
                        end else if (rx_valid) begin
                            resp_valid_q <= 1'b1;
                            if (ovf_q) begin
                                resp_nack_q <= 1'b1;
                            end else if (!writable_s) begin
                                resp_nack_q <= 1'b1;
                                state_q     <= S_IGNORE;
                            end else begin
                                resp_nack_q <= 1'b0;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= ptr_q;
                                mem_wdata_q <= rx_byte;
                                ptr_q       <= ptr_inc_s;
                                ovf_q       <= ovf_inc_s;
                            end
                        end
                    end
                    S_RD_IDLE, S_RD_WAIT: begin
                        if (rx_valid) begin
                            err_q <= 1'b1;
                        end
                        if (tx_req) begin
                            // An overflowed pointer still goes through the fetch timing, returning 0xFF
                            state_q <= S_RD_FETCH;
                            pend_q  <= 1'b1;
                            lat_q   <= 3'd0;
                            ff_q    <= ovf_q;
                            if (!ovf_q) begin
                                mem_re_q   <= 1'b1;
                                mem_addr_q <= ptr_q;
                                ptr_q      <= ptr_inc_s;
                                ovf_q      <= ovf_inc_s;
                            end
                        end else if ((state_q == S_RD_WAIT) && mack_valid) begin
                            state_q <= mack_nack ? S_IGNORE : S_RD_IDLE;
                        end
                    end
                    S_RD_FETCH: begin
                        if (rx_valid || tx_req) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_IGNORE: begin
                        if (rx_valid) begin
                            resp_valid_q <= 1'b1;
                            resp_nack_q  <= 1'b1;
                        end
                        if (tx_req) begin
                            if (pend_q) begin
                                err_q <= 1'b1;
                            end else begin
                                pend_q <= 1'b1;
                                ff_q   <= 1'b1;
                                lat_q  <= 3'd0;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_nack  = resp_nack_q;
    assign tx_valid   = tx_valid_q;
    assign tx_byte    = tx_byte_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/i2c_mem_access_ctrl.md
# i2c_mem_access_ctrl

Parametrised I2C subordinate memory-access controller; next generation of the single-byte-address RAM sequencer. It sits between the I2C byte/bit layer and an on-chip byte-wide RAM. It supports multi-byte addressing, configurable RAM read latency, wrap or end-of-memory stop, a write-protected upper region, and a current-address pointer that persists across transactions. The byte layer talks to it through event strobes instead of a raw state vector.

## Interface
- ADDR_BYTES, 2: number of address bytes, MSB first (1..3); ADDR_BYTES*8 >= MEM_AW.
- MEM_AW, 10: RAM address width; depth = 2**MEM_AW.
- RD_LATENCY, 1: cycles from mem_re to valid mem_rdata (1..4).
- WRAP_EN, 1: 1 = pointer wraps top->0; 0 = stop at top.
- WP_EN, 0: 1 = enable write protection.
- WP_BASE, 2**MEM_AW-64: addresses >= WP_BASE are read-only when WP_EN=1.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start_det  in  1  pulse: START or repeated START seen.
- stop_det  in  1  pulse: STOP seen.
- hdr_valid  in  1  pulse: device address byte matched this subordinate.
- hdr_rw  in  1  R/W bit with hdr_valid (1 = read).
- rx_valid  in  1  pulse: data byte from master complete.
- rx_byte  in  8  byte qualified by rx_valid.
- resp_valid  out  1  pulse: ACK decision for the last rx_valid.
- resp_nack  out  1  qualified by resp_valid; 1 = NACK.
- tx_req  in  1  pulse: byte layer needs the next read byte.
- tx_valid  out  1  pulse: tx_byte ready.
- tx_byte  out  8  read data.
- mack_valid  in  1  pulse: master ACK slot after a read byte.
- mack_nack  in  1  qualified by mack_valid; 1 = master NACK.
- mem_addr  out  MEM_AW  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write strobe, one cycle.
- mem_re  out  1  RAM read strobe, one cycle.
- mem_rdata  in  8  RAM read data, valid RD_LATENCY cycles after mem_re.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on protocol error.

## Operation
- States: IDLE, ADDR (byte counter 0..ADDR_BYTES-1), WR_DATA, RD_IDLE, RD_FETCH, RD_WAIT_ACK, IGNORE.
- IDLE: hdr_valid&!hdr_rw -> ADDR with the counter cleared. hdr_valid&hdr_rw -> RD_IDLE, reading from the current pointer.
- ADDR: each rx_valid shifts rx_byte into the address shift register and is ACKed. On the last byte, if the bits above MEM_AW are zero, load the pointer and go to WR_DATA. Otherwise NACK that byte, keep the pointer, and go to IGNORE.
- WR_DATA: rx_valid with the pointer writable (not WP_EN or ptr < WP_BASE) and no overflow:
  - mem_we=1, mem_addr=ptr, mem_wdata=rx_byte, ACK, ptr++.
  - Protected address: NACK, no write, go to IGNORE.
- WR_DATA, hdr_valid after repeated START: rw=1 -> RD_IDLE (combined format); rw=0 -> ADDR.
- RD_IDLE/RD_WAIT_ACK: tx_req -> RD_FETCH, mem_re=1, mem_addr=ptr, ptr++. Capture mem_rdata RD_LATENCY cycles later, pulse tx_valid, go to RD_WAIT_ACK.
- RD_WAIT_ACK: mack_valid&!mack_nack -> RD_IDLE; mack_valid&mack_nack -> IGNORE.
- Pointer at 2**MEM_AW-1, increment:
  - WRAP_EN=1: pointer goes to 0.
  - WRAP_EN=0: pointer holds and ovf flag is set. Later writes are NACKed with no mem_we. Later reads return 8'hFF with no mem_re and the same tx_valid timing. ovf clears when the pointer is loaded.
- IGNORE: all rx_valid get NACK; tx_req returns 8'hFF; leave only on start_det/stop_det.
- stop_det: -> IDLE from any state. start_det: -> IDLE awaiting hdr_valid. Both keep the pointer.
- Protocol errors, each giving an err pulse and otherwise ignored: rx_valid in a read state, tx_req in a write or ADDR state, tx_req while RD_FETCH is in flight.
- Reset values: all outputs 0, tx_byte=0, mem_addr=0, pointer=0, ovf=0, state IDLE.

## Timing
- rx_valid at cycle t -> resp_valid/resp_nack at t+1. mem_we (if any) at t+1.
- tx_req at t -> mem_re at t+1, tx_valid at t+2+RD_LATENCY. Same timing for the 8'hFF cases.
- mem_addr is registered; it is stable in the mem_re/mem_we cycle and holds between accesses.
- stop_det and rx_valid in the same cycle: stop wins; no resp_valid, no write.
- start_det/stop_det during RD_FETCH: drop the in-flight read; tx_valid suppressed; pointer already incremented.
- rst_n low mid-operation: immediate return to reset values; in-flight read discarded.
- err is exactly one cycle per offending strobe.

## Test plan
- Write, ADDR_BYTES=2: hdr w, rx 0x01, 0x23, 0xA5, 0x5A -> four ACKs; mem_we at 0x123=0xA5 and 0x124=0x5A; each resp_valid 1 cycle after rx_valid.
- Combined read, RD_LATENCY=2: hdr w, addr 0x0123, repeated START, hdr r, tx_req x2 with master ACK then NACK -> tx_byte 0xA5, 0x5A, each tx_valid 4 cycles after tx_req; pointer=0x125; state IGNORE until stop.
- Current-address read: after the STOP, hdr r, tx_req -> mem_re at 0x125 (pointer kept across STOP).
- Wrap: WRAP_EN=1, write at 0x3FF then one more byte -> second byte written to 0x000. WRAP_EN=0 -> second byte NACKed, no mem_we; a read returns 0xFF with no mem_re.
- Write protect: WP_EN=1, WP_BASE=0x3C0, write at 0x3BF then 0x3C0 -> first ACK+write; second NACK, no write; next rx NACK (IGNORE).
- Bad address/reset: addr 0x0400 with MEM_AW=10 -> NACK on the 2nd address byte, pointer unchanged. rst_n pulsed during RD_FETCH -> no tx_valid, all outputs 0, pointer 0.
